// File: rtl/pio_pkg.sv
// Shared types for the PIO state-machine blocks: instruction-address width and type.
// No logic; widths here size pc, jump targets and the wrap bounds everywhere.
// Optional feature macro used by importers: PIO_PC_WRAP_FLAG_EN.
package pio_pkg;

  localparam int PIO_ADDR_W = 5;

  typedef logic [PIO_ADDR_W-1:0] pio_addr_t;

endpackage

// File: rtl/pio_program_counter_if.sv
// Controller <-> program-counter bundle: decode controls, wrap bounds, current pc.
// Latency: none (wires only); pc and wrapped are registered inside the counter.
// Backpressure: none; pc_en low is the only stall. Macro PIO_PC_WRAP_FLAG_EN adds wrapped.
interface pio_program_counter_if;
  import pio_pkg::*;

  pio_addr_t wrap_top;
  pio_addr_t wrap_bottom;
  pio_addr_t jump;
  logic      jump_en;
  logic      pc_en;
  pio_addr_t pc;
`ifdef PIO_PC_WRAP_FLAG_EN
  logic      wrapped;
`endif

  // Controller side: drives decode controls and bounds, observes pc.
  modport master (
    output wrap_top, wrap_bottom, jump, jump_en, pc_en,
`ifdef PIO_PC_WRAP_FLAG_EN
    input  wrapped,
`endif
    input  pc
  );

  // Counter side.
  modport slave (
    input  wrap_top, wrap_bottom, jump, jump_en, pc_en,
`ifdef PIO_PC_WRAP_FLAG_EN
    output wrapped,
`endif
    output pc
  );

endinterface

// File: rtl/pio_program_counter_pc_next.sv
// Combinational next-pc select: stall, jump, wrap, increment, in that priority.
// Latency: zero (pure logic); the controller may reuse it for lookahead.
// Backpressure: pc_en low holds pc and drops any jump request.
module pio_pc_next #(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              pc_en,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump,
  input  logic [ADDR_W-1:0] wrap_top,
  input  logic [ADDR_W-1:0] wrap_bottom,
  output logic [ADDR_W-1:0] pc_next,
  output logic              wrap_taken
);

  // Priority select; the jump outranks the wrap even when pc sits on wrap_bottom.
  always_comb begin
    pc_next    = pc;
    wrap_taken = 1'b0;
    if (pc_en) begin
      if (jump_en) begin
        pc_next = jump;
      end else if (pc == wrap_bottom) begin
        pc_next    = wrap_top;
        wrap_taken = 1'b1;
      end else begin
        // Natural modulo 2**ADDR_W roll-over (31 -> 0) from truncation.
        pc_next = pc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pio_program_counter.sv
// PIO instruction-address counter: registered shell around pio_pc_next.
// Latency: pc updates one clk after inputs are sampled; no comb path to pc.
// Backpressure: pc_en low stalls. Optional macro PIO_PC_WRAP_FLAG_EN adds a wrapped pulse.
module pio_program_counter
  import pio_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  pio_program_counter_if.slave         bus
);

  pio_addr_t pc_q;
  pio_addr_t pc_d;
  logic      wrap_taken;

  pio_pc_next #(
    .ADDR_W      (PIO_ADDR_W)
  ) u_pc_next (
    .pc          (pc_q),
    .pc_en       (bus.pc_en),
    .jump_en     (bus.jump_en),
    .jump        (bus.jump),
    .wrap_top    (bus.wrap_top),
    .wrap_bottom (bus.wrap_bottom),
    .pc_next     (pc_d),
    .wrap_taken  (wrap_taken)
  );

  // Program counter register; reset forces address 0 at once, independent of clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.pc = pc_q;

`ifdef PIO_PC_WRAP_FLAG_EN
  logic wrapped_q;
  logic wrapped_d;

  // Wrap flag is high only for the cycle following an edge that took the wrap path.
  always_comb begin
    wrapped_d = wrap_taken;
  end

  // Wrap flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrapped_q <= 1'b0;
    end else begin
      wrapped_q <= wrapped_d;
    end
  end

  assign bus.wrapped = wrapped_q;
`else
  // Without the flag port the wrap indication has no consumer.
  logic unused_wrap;
  assign unused_wrap = wrap_taken;
`endif

endmodule

// File: tb/tb_pio_program_counter.sv
// Self-checking bench for pio_program_counter: directed plan plus random traffic.
// Reference model works on plain integers from the update rules.
// Also checks the wrapped flag when PIO_PC_WRAP_FLAG_EN is defined.
module tb_pio_program_counter;
  import pio_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   m_pc   = 0;   // model program counter
  int   m_wr   = 0;   // model wrapped flag
  int   wt     = 0;
  int   wb     = 31;

  always #5 clk = ~clk;

  pio_program_counter_if bus ();

  pio_program_counter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk(tag, int'(bus.pc), m_pc);
`ifdef PIO_PC_WRAP_FLAG_EN
    chk({tag, "_wrapped"}, int'(bus.wrapped), m_wr);
`endif
  endtask

  // One clock: drive inputs (just after an edge), update model, check after next edge.
  task automatic cyc(input string tag, input bit en, input bit jen, input int j);
    bus.pc_en       = en;
    bus.jump_en     = jen;
    bus.jump        = pio_addr_t'(j);
    bus.wrap_top    = pio_addr_t'(wt);
    bus.wrap_bottom = pio_addr_t'(wb);
    m_wr = 0;
    if (en) begin
      if (jen) begin
        m_pc = j;
      end else if (m_pc == wb) begin
        m_pc = wt;
        m_wr = 1;
      end else begin
        m_pc = (m_pc + 1) % 32;
      end
    end
    @(posedge clk);
    #1;
    chk_state(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_pc = 0;
    m_wr = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bus.pc_en       = 1'b0;
    bus.jump_en     = 1'b0;
    bus.jump        = '0;
    bus.wrap_top    = '0;
    bus.wrap_bottom = 5'd31;
    #2;
    chk_state("reset_state");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Count to 7, then assert reset asynchronously between edges.
    wt = 0; wb = 31;
    for (int i = 0; i < 7; i++) cyc("count_to_7", 1'b1, 1'b0, 0);
    #2;
    rst = 1'b1;
    #1;
    m_pc = 0; m_wr = 0;
    chk_state("async_reset_immediate");
    @(posedge clk);
    #1;
    chk_state("reset_held");
    rst = 1'b0;
    cyc("first_after_reset", 1'b1, 1'b0, 0);

    // Free run over the full space: 0..31, 0, 1, 2.
    do_reset();
    for (int i = 0; i < 34; i++) cyc("free_run", 1'b1, 1'b0, 0);

    // Wrap window 4..6 from 0.
    do_reset();
    wt = 4; wb = 6;
    for (int i = 0; i < 10; i++) cyc("window_4_6", 1'b1, 1'b0, 0);
    cyc("window_to_5", 1'b1, 1'b0, 0);
    cyc("window_to_6", 1'b1, 1'b0, 0);

    // Jump beats wrap at pc == wrap_bottom, then counts out-of-window and rolls over.
    cyc("jump_priority", 1'b1, 1'b1, 20);
    for (int i = 0; i < 19; i++) cyc("after_jump", 1'b1, 1'b0, 0);

    // Stall drops a requested jump.
    cyc("jump_to_9", 1'b1, 1'b1, 9);
    for (int i = 0; i < 3; i++) cyc("stall", 1'b0, 1'b1, 2);
    cyc("resume", 1'b1, 1'b0, 0);

    // Degenerate window: holds at 12.
    wt = 12; wb = 12;
    for (int i = 0; i < 5; i++) cyc("degenerate_hold", 1'b1, 1'b0, 0);
    cyc("degenerate_jump", 1'b1, 1'b1, 3);
    for (int i = 0; i < 12; i++) cyc("degenerate_recount", 1'b1, 1'b0, 0);

    // Inverted bounds (top > bottom) get no special handling.
    wt = 25; wb = 3;
    for (int i = 0; i < 40; i++) cyc("inverted_bounds", 1'b1, 1'b0, 0);

    // Random traffic, bounds changing on the fly.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        wt = int'($urandom_range(0, 31));
        wb = int'($urandom_range(0, 31));
      end
      cyc("random",
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 6) == 0),
          int'($urandom_range(0, 31)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound on simulated time.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
